// File: rtl/fft_pkg.sv
// Shared FFT host constants: FSM state encodings and default frame geometry.
package fft_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_WAIT   = 3'd2,
      ST_RD_REQ = 3'd3,
      ST_RD_CAP = 3'd4,
      ST_OUT    = 3'd5
   } state_t;

   localparam int FFT_DEPTH       = 32;
   localparam int FFT_WAIT_CYCLES = 64;

endpackage

// File: rtl/fft_host_ctrl.sv
// Streams one frame into the FFT input bank, waits WAIT_CYCLES, then streams results out at 3 cycles/bin.
// Writes land one cycle after the in_valid/in_ready handshake; out_ready low freezes the result and stalls reads.
module fft_host_ctrl
   import fft_pkg::*;
#(
   parameter int ADDR_WIDTH  = 5,
   parameter int DATA_WIDTH  = 16,
   parameter int DEPTH       = FFT_DEPTH,
   parameter int WAIT_CYCLES = FFT_WAIT_CYCLES
)(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [DATA_WIDTH-1:0]   in_data,
   output logic [ADDR_WIDTH-1:0]   m_addr,
   output logic [DATA_WIDTH-1:0]   m_data,
   output logic                    m_we,
   output logic [ADDR_WIDTH-1:0]   s_addr,
   output logic                    s_re,
   input  logic [2*DATA_WIDTH-1:0] s_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [2*DATA_WIDTH-1:0] out_data,
   output logic [ADDR_WIDTH-1:0]   out_index,
   output logic                    out_last,
   output logic                    busy,
   output logic                    done
);

   localparam int WCW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(DEPTH - 1);
   localparam logic [WCW-1:0]        WAIT_LOAD = WCW'(WAIT_CYCLES - 1);

   state_t                state;
   logic [ADDR_WIDTH-1:0] wr_cnt;
   logic [ADDR_WIDTH-1:0] rd_cnt;
   logic [WCW-1:0]        wait_cnt;

   assign busy      = (state != ST_IDLE);
   assign in_ready  = (state == ST_LOAD);
   assign s_re      = (state == ST_RD_REQ);
   assign s_addr    = (state == ST_RD_REQ) ? rd_cnt : '0;
   assign out_valid = (state == ST_OUT);
   assign out_last  = (state == ST_OUT) && (rd_cnt == LAST_IDX);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_IDLE;
         wr_cnt    <= '0;
         rd_cnt    <= '0;
         wait_cnt  <= '0;
         m_we      <= 1'b0;
         m_addr    <= '0;
         m_data    <= '0;
         out_data  <= '0;
         out_index <= '0;
         done      <= 1'b0;
      end else begin
         m_we <= 1'b0;
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               wr_cnt <= '0;
               state  <= ST_LOAD;
            end
            ST_LOAD: begin
               if (in_valid) begin
                  m_we   <= 1'b1;
                  m_addr <= wr_cnt;
                  m_data <= in_data;
                  // Counter parks on the last index rather than wrapping; IDLE reloads it.
                  if (wr_cnt == LAST_IDX) begin
                     state    <= ST_WAIT;
                     wait_cnt <= WAIT_LOAD;
                  end else begin
                     wr_cnt <= wr_cnt + ADDR_WIDTH'(1);
                  end
               end
            end
            ST_WAIT: begin
               if (wait_cnt == '0) begin
                  state  <= ST_RD_REQ;
                  rd_cnt <= '0;
               end else begin
                  wait_cnt <= wait_cnt - WCW'(1);
               end
            end
            ST_RD_REQ: state <= ST_RD_CAP;
            ST_RD_CAP: begin
               out_data  <= s_data;
               out_index <= rd_cnt;
               state     <= ST_OUT;
            end
            ST_OUT: begin
               if (out_ready) begin
                  if (rd_cnt == LAST_IDX) begin
                     state <= ST_IDLE;
                     done  <= 1'b1;
                  end else begin
                     rd_cnt <= rd_cnt + ADDR_WIDTH'(1);
                     state  <= ST_RD_REQ;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fft_host_ctrl.sv
// Cycle-accurate frame-level scoreboard for fft_host_ctrl with randomized valid/ready traffic and a result-bank model.
module tb_fft_host_ctrl;

   localparam int AW    = 5;
   localparam int DW    = 16;
   localparam int DEPTH = 32;
   localparam int WAITC = 64;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] in_data = '0;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_data;
   logic          m_we;
   logic [AW-1:0] s_addr;
   logic          s_re;
   logic [2*DW-1:0] s_data = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [2*DW-1:0] out_data;
   logic [AW-1:0] out_index;
   logic          out_last;
   logic          busy;
   logic          done;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [2*DW-1:0] bank [DEPTH];
   logic            exp_we    = 1'b0;
   logic [AW-1:0]   exp_maddr = '0;
   logic [DW-1:0]   exp_mdata = '0;

   fft_host_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .WAIT_CYCLES(WAITC)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .m_addr(m_addr), .m_data(m_data), .m_we(m_we),
      .s_addr(s_addr), .s_re(s_re), .s_data(s_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_index(out_index), .out_last(out_last),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Result bank: registered read, data valid the cycle after s_re.
   always @(posedge clk) if (s_re) s_data <= bank[s_addr];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk_mport(input string p);
      check({p, "_m_we"}, m_we, exp_we);
      check({p, "_m_addr"}, m_addr, exp_maddr);
      check({p, "_m_data"}, m_data, exp_mdata);
   endtask

   task automatic chk_reset(input string p);
      check({p, "_busy"}, busy, 0);
      check({p, "_in_ready"}, in_ready, 0);
      check({p, "_s_re"}, s_re, 0);
      check({p, "_s_addr"}, s_addr, 0);
      check({p, "_out_valid"}, out_valid, 0);
      check({p, "_out_last"}, out_last, 0);
      check({p, "_out_data"}, out_data, 0);
      check({p, "_out_index"}, out_index, 0);
      check({p, "_done"}, done, 0);
      exp_we = 1'b0; exp_maddr = '0; exp_mdata = '0;
      chk_mport(p);
   endtask

   task automatic chk_idle(input string p, input bit exp_done);
      check({p, "_busy"}, busy, 0);
      check({p, "_in_ready"}, in_ready, 0);
      check({p, "_s_re"}, s_re, 0);
      check({p, "_out_valid"}, out_valid, 0);
      check({p, "_done"}, done, exp_done);
   endtask

   task automatic load_frame(input bit ramp, output int hs_cyc);
      int k = 0;
      int gap = 0;
      bit v;
      logic [DW-1:0] smp;
      hs_cyc = 0;
      while (k < DEPTH) begin
         v   = ramp ? (gap == 0) : ($urandom_range(0, 3) != 0);
         smp = (ramp && v) ? DW'(k) : DW'($urandom);
         in_valid  = v;
         in_data   = smp;
         out_ready = 1'($urandom_range(0, 1));
         check("ld_in_ready", in_ready, 1);
         check("ld_busy", busy, 1);
         check("ld_s_re", s_re, 0);
         check("ld_out_valid", out_valid, 0);
         check("ld_done", done, 0);
         chk_mport("ld");
         tick();
         if (v) begin
            exp_we = 1'b1; exp_maddr = AW'(k); exp_mdata = smp;
            hs_cyc = cyc - 1;
            k++;
            if (ramp && k == 11) gap = 3;
         end else begin
            exp_we = 1'b0;
            if (gap > 0) gap--;
         end
      end
   endtask

   task automatic wait_phase(input int hs_cyc);
      for (int i = 0; i < WAITC; i++) begin
         in_valid  = 1'($urandom_range(0, 1));
         in_data   = DW'($urandom);
         out_ready = 1'($urandom_range(0, 1));
         check("wt_in_ready", in_ready, 0);
         check("wt_busy", busy, 1);
         check("wt_s_re", s_re, 0);
         check("wt_out_valid", out_valid, 0);
         chk_mport("wt");
         tick();
         exp_we = 1'b0;
      end
      check("first_sre_latency", cyc - hs_cyc, WAITC + 1);
   endtask

   task automatic read_frame(input bit scripted, input int rst_at, output bit aborted);
      int stall;
      bit r;
      aborted = 1'b0;
      for (int a = 0; a < DEPTH; a++) begin
         out_ready = 1'($urandom_range(0, 1));
         in_valid  = 1'($urandom_range(0, 1));
         check("rq_s_re", s_re, 1);
         check("rq_s_addr", s_addr, a);
         check("rq_out_valid", out_valid, 0);
         check("rq_in_ready", in_ready, 0);
         check("rq_busy", busy, 1);
         chk_mport("rq");
         tick();
         check("cp_s_re", s_re, 0);
         check("cp_out_valid", out_valid, 0);
         tick();
         stall = 0;
         r = 1'b0;
         while (!r) begin
            if (scripted) r = !(a == 7 && stall < 5);
            else          r = (stall >= 8) || ($urandom_range(0, 2) != 0);
            check("out_valid", out_valid, 1);
            check("out_data", out_data, bank[a]);
            check("out_index", out_index, a);
            check("out_last", out_last, a == DEPTH - 1);
            check("out_s_re", s_re, 0);
            check("out_busy", busy, 1);
            if (a == rst_at) begin
               rst = 1'b0;
               #1;
               chk_reset("rst_mid");
               aborted = 1'b1;
               return;
            end
            out_ready = r;
            tick();
            stall++;
         end
      end
      out_ready = 1'($urandom_range(0, 1));
      chk_idle("end", 1'b1);
      check("end_out_last", out_last, 0);
      tick();
   endtask

   initial begin
      int  hs;
      bit  ab;
      for (int a = 0; a < DEPTH; a++) bank[a] = '0;
      tick();
      chk_reset("por");
      tick();
      chk_reset("por2");
      rst = 1'b1;
      chk_idle("rel", 1'b0);
      tick();

      // Frame 0: ramp with a 3-cycle gap after sample 10, pattern results, 5-cycle stall at bin 7.
      for (int a = 0; a < DEPTH; a++) begin
         bank[a][31:16] = 16'(a);
         bank[a][15:0]  = ~16'(a);
      end
      load_frame(1'b1, hs);
      wait_phase(hs);
      read_frame(1'b1, -1, ab);

      // Frame 1: random traffic, reset while bin 12 is presented.
      for (int a = 0; a < DEPTH; a++) bank[a] = $urandom;
      load_frame(1'b0, hs);
      wait_phase(hs);
      read_frame(1'b0, 12, ab);
      check("aborted", ab, 1);
      tick();
      chk_reset("rst_hold");
      rst = 1'b1;
      chk_idle("rst_rel", 1'b0);
      tick();

      // Frame 2: full random frame after the mid-frame reset; writes restart at 0.
      for (int a = 0; a < DEPTH; a++) bank[a] = $urandom;
      load_frame(1'b0, hs);
      wait_phase(hs);
      read_frame(1'b0, -1, ab);
      check("next_load_in_ready", in_ready, 1);
      check("next_load_done", done, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
